// File: rtl/cpri_rx_read_sched.sv
// Lock-step read scheduler for the per-lane CPRI rx buffers: one common read enable per
// symbol burst, slot/symbol tracking from the radio frame pulse, and flushing of skewed lanes.
module cpri_rx_read_sched #(
   parameter int unsigned LANE      = 8,
   parameter int unsigned BURST     = 96,
   parameter int unsigned TMO       = 1024,
   parameter int unsigned FLUSH_LEN = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_enable,
   input  logic            i_rx_rfp,
   input  logic [LANE-1:0] i_lane_mask,
   input  logic [LANE-1:0] i_buf_vld,
   input  logic [LANE-1:0] i_symb_eop,
   output logic            o_rd_en,
   output logic            o_sop,
   output logic            o_eop,
   output logic [6:0]      o_beat,
   output logic [3:0]      o_symb_idx,
   output logic [6:0]      o_slot_idx,
   output logic [LANE-1:0] o_flush,
   output logic [LANE-1:0] o_lane_miss,
   output logic            o_skew_err,
   output logic            o_align_err,
   output logic            o_busy
);

   localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam int unsigned FW = $clog2(FLUSH_LEN + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TMO - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
   localparam logic [6:0]    BEAT_LAST  = 7'(BURST - 1);

   typedef enum logic [1:0] {StIdle, StWait, StRead, StFlush} state_e;

   state_e          state_q, state_d;
   logic [LANE-1:0] act_q, act_d;
   logic [6:0]      beat_q, beat_d;
   logic [3:0]      symb_q, symb_d;
   logic [6:0]      slot_q, slot_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [LANE-1:0] flush_q, flush_d;
   logic [LANE-1:0] miss_q, miss_d;
   logic            skew_q, skew_d;
   logic            align_q, align_d;
   logic            pend_q, pend_d;

   logic allv, anyv, rfp_now;

   assign allv    = &(i_buf_vld | ~act_q);
   assign anyv    = |(i_buf_vld & act_q);
   // A frame pulse seen during READ/FLUSH (or on the exit cycle itself) wins over the advance.
   assign rfp_now = pend_q | i_rx_rfp;

   assign o_rd_en     = (state_q == StRead) & allv & i_enable;
   assign o_sop       = o_rd_en & (beat_q == 7'd0);
   assign o_eop       = o_rd_en & (beat_q == BEAT_LAST);
   assign o_beat      = beat_q;
   assign o_symb_idx  = symb_q;
   assign o_slot_idx  = slot_q;
   assign o_flush     = flush_q;
   assign o_lane_miss = miss_q;
   assign o_skew_err  = skew_q;
   assign o_align_err = align_q;
   assign o_busy      = (state_q != StIdle);

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      beat_d  = beat_q;
      symb_d  = symb_q;
      slot_d  = slot_q;
      tmo_d   = tmo_q;
      fcnt_d  = fcnt_q;
      flush_d = flush_q;
      miss_d  = miss_q;
      skew_d  = 1'b0;
      align_d = 1'b0;
      pend_d  = pend_q;

      unique case (state_q)
         StIdle: begin
            if (i_enable && i_rx_rfp) begin
               state_d = StWait;
               act_d   = i_lane_mask;
               symb_d  = '0;
               slot_d  = '0;
               miss_d  = '0;
               tmo_d   = '0;
            end
         end
         StWait: begin
            if (i_rx_rfp) begin
               symb_d = '0;
               slot_d = '0;
               miss_d = '0;
            end
            if (!anyv) begin
               tmo_d = '0;
            end else if (!allv) begin
               tmo_d = tmo_q + 1'b1;
            end
            if (allv && (act_q != '0)) begin
               state_d = StRead;
               tmo_d   = '0;
               beat_d  = '0;
            end else if (anyv && !allv && (tmo_q == TMO_LAST)) begin
               state_d = StFlush;
               tmo_d   = '0;
               fcnt_d  = '0;
               flush_d = act_q & i_buf_vld;
               miss_d  = act_q & ~i_buf_vld;
               skew_d  = 1'b1;
            end
         end
         StRead: begin
            if (i_rx_rfp) pend_d = 1'b1;
            if (o_rd_en) begin
               if (beat_q == BEAT_LAST) begin
                  state_d = StWait;
                  act_d   = i_lane_mask;
                  beat_d  = '0;
                  tmo_d   = '0;
                  align_d = ((i_symb_eop & act_q) != act_q);
                  if (rfp_now) begin
                     symb_d = '0;
                     slot_d = '0;
                     miss_d = '0;
                     pend_d = 1'b0;
                  end else if (symb_q == 4'd13) begin
                     symb_d = '0;
                     slot_d = (slot_q == 7'd79) ? 7'd0 : slot_q + 7'd1;
                  end else begin
                     symb_d = symb_q + 4'd1;
                  end
               end else begin
                  beat_d = beat_q + 7'd1;
               end
            end
         end
         StFlush: begin
            if (i_rx_rfp) pend_d = 1'b1;
            if (fcnt_q == FLUSH_LAST) begin
               state_d = StWait;
               act_d   = i_lane_mask;
               flush_d = '0;
               fcnt_d  = '0;
               tmo_d   = '0;
               if (rfp_now) begin
                  symb_d = '0;
                  slot_d = '0;
                  miss_d = '0;
                  pend_d = 1'b0;
               end
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Disable abandons whatever is in flight; position and miss history are kept.
      if (!i_enable) begin
         state_d = StIdle;
         beat_d  = '0;
         tmo_d   = '0;
         fcnt_d  = '0;
         flush_d = '0;
         pend_d  = 1'b0;
         skew_d  = 1'b0;
         align_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StIdle;
         act_q   <= '0;
         beat_q  <= '0;
         symb_q  <= '0;
         slot_q  <= '0;
         tmo_q   <= '0;
         fcnt_q  <= '0;
         flush_q <= '0;
         miss_q  <= '0;
         skew_q  <= 1'b0;
         align_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         beat_q  <= beat_d;
         symb_q  <= symb_d;
         slot_q  <= slot_d;
         tmo_q   <= tmo_d;
         fcnt_q  <= fcnt_d;
         flush_q <= flush_d;
         miss_q  <= miss_d;
         skew_q  <= skew_d;
         align_q <= align_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_cpri_rx_read_sched.sv
// Directed bench for cpri_rx_read_sched: aligned bursts, stall, eop mismatch, rfp mid-burst,
// masking, skew timeout/flush, rfp in WAIT, disable mid-burst and empty mask.
module tb_cpri_rx_read_sched;

   localparam int BURST = 96;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_enable;
   logic       i_rx_rfp;
   logic [7:0] i_lane_mask;
   logic [7:0] i_buf_vld;
   logic [7:0] i_symb_eop;
   logic       o_rd_en, o_sop, o_eop, o_skew_err, o_align_err, o_busy;
   logic [6:0] o_beat, o_slot_idx;
   logic [3:0] o_symb_idx;
   logic [7:0] o_flush, o_lane_miss;

   int n_cmp = 0;
   int n_err = 0;

   cpri_rx_read_sched #(
      .LANE      (8),
      .BURST     (BURST),
      .TMO       (1024),
      .FLUSH_LEN (4)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .i_rx_rfp    (i_rx_rfp),
      .i_lane_mask (i_lane_mask),
      .i_buf_vld   (i_buf_vld),
      .i_symb_eop  (i_symb_eop),
      .o_rd_en     (o_rd_en),
      .o_sop       (o_sop),
      .o_eop       (o_eop),
      .o_beat      (o_beat),
      .o_symb_idx  (o_symb_idx),
      .o_slot_idx  (o_slot_idx),
      .o_flush     (o_flush),
      .o_lane_miss (o_lane_miss),
      .o_skew_err  (o_skew_err),
      .o_align_err (o_align_err),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Inputs change just after the rising edge; outputs are sampled mid-cycle.
   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic burst(input string tag, input logic [7:0] vld_base, input logic [7:0] post_vld,
                        input int stall_at, input int stall_len, input logic [7:0] stall_lanes,
                        input logic [7:0] last_eop, input int rfp_at,
                        input int exp_symb, input int exp_slot, input int exp_pre,
                        input int exp_low, input int exp_post_symb, input int exp_post_slot,
                        input logic exp_align);
      int  beats = 0;
      int  low = 0;
      int  pre = 0;
      int  st = 0;
      int  bad = 0;
      bit  rfp_done = 1'b0;
      for (int guard = 0; guard < 400 && beats < BURST; guard++) begin
         cycle();
         i_buf_vld  = vld_base;
         i_symb_eop = 8'hFF;
         i_rx_rfp   = 1'b0;
         if (beats == stall_at && st < stall_len) begin
            i_buf_vld = vld_base & ~stall_lanes;
            st++;
         end
         if (beats == BURST - 1) i_symb_eop = last_eop;
         if (beats == rfp_at && !rfp_done) begin
            i_rx_rfp = 1'b1;
            rfp_done = 1'b1;
         end
         look();
         if (o_rd_en) begin
            if (o_beat !== 7'(beats) || o_sop !== (beats == 0) || o_eop !== (beats == BURST - 1))
               bad++;
            beats++;
         end else if (beats == 0) begin
            pre++;
         end else begin
            low++;
            if (o_beat !== 7'(beats)) bad++;
         end
         if (o_symb_idx !== 4'(exp_symb) || o_slot_idx !== 7'(exp_slot) || o_skew_err !== 1'b0 ||
             o_align_err !== 1'b0 || o_busy !== 1'b1)
            bad++;
      end
      chk({tag, "/beats"}, beats, BURST);
      chk({tag, "/pre_wait"}, pre, exp_pre);
      chk({tag, "/stall_cyc"}, low, exp_low);
      chk({tag, "/beat_seq"}, bad, 0);
      cycle();
      i_buf_vld  = post_vld;
      i_symb_eop = 8'hFF;
      i_rx_rfp   = 1'b0;
      look();
      chk({tag, "/post_rd_en"}, o_rd_en, 0);
      chk({tag, "/post_symb"}, o_symb_idx, exp_post_symb);
      chk({tag, "/post_slot"}, o_slot_idx, exp_post_slot);
      chk({tag, "/post_align"}, o_align_err, exp_align);
   endtask

   initial begin
      int skew_at;
      int rd_cnt;
      int fl;
      int skew_after;
      int cnt;
      int sk;

      i_reset = 1'b1; i_enable = 1'b0; i_rx_rfp = 1'b0;
      i_lane_mask = 8'h00; i_buf_vld = 8'h00; i_symb_eop = 8'hFF;
      repeat (3) cycle();
      look();
      chk("rst/busy", o_busy, 0);
      chk("rst/rd_en", o_rd_en, 0);
      chk("rst/symb", o_symb_idx, 0);
      chk("rst/slot", o_slot_idx, 0);
      chk("rst/flush", o_flush, 0);
      chk("rst/miss", o_lane_miss, 0);
      chk("rst/errs", {o_skew_err, o_align_err}, 0);
      chk("rst/beat", o_beat, 0);

      // Start: rfp in IDLE with every lane enabled and valid.
      cycle();
      i_reset = 1'b0; i_enable = 1'b1; i_lane_mask = 8'hFF; i_buf_vld = 8'hFF; i_rx_rfp = 1'b1;
      look();
      chk("start/busy", o_busy, 0);

      // 14 aligned bursts: symb 0..13 then wrap with slot -> 1.
      burst("aligned0", 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFF, -1, 0, 0, 1, 0, 1, 0, 1'b0);
      for (int k = 1; k < 14; k++)
         burst($sformatf("aligned%0d", k), 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFF, -1,
               k, 0, 0, 0, (k + 1) % 14, (k == 13) ? 1 : 0, 1'b0);

      // Lane 3 drops valid for 5 cycles at beat 40.
      burst("stall", 8'hFF, 8'hFF, 40, 5, 8'h08, 8'hFF, -1, 0, 1, 0, 5, 1, 1, 1'b0);

      // Lane 2 misses eop on the last beat.
      burst("eop_mis", 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFB, -1, 1, 1, 0, 0, 2, 1, 1'b1);

      // Walk to slot 3 symb 7.
      for (int k = 0; k < 33; k++)
         burst($sformatf("walk%0d", k), 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFF, -1,
               (2 + k) % 14, 1 + (2 + k) / 14, 0, 0, (3 + k) % 14, 1 + (3 + k) / 14, 1'b0);

      // Frame pulse at beat 50 of slot 3 symb 7 restarts the count instead of advancing.
      burst("rfp_mid", 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFF, 50, 7, 3, 0, 0, 0, 0, 1'b0);

      // Mask 0x0F latched at this eop; next burst runs with lanes 4-7 idle.
      i_lane_mask = 8'h0F;
      burst("mask_a", 8'hFF, 8'hFF, -1, 0, 8'h00, 8'hFF, -1, 0, 0, 0, 0, 1, 0, 1'b0);
      i_lane_mask = 8'hFF;
      burst("mask_b", 8'h0F, 8'h7F, -1, 0, 8'h00, 8'hFF, -1, 1, 0, 0, 0, 2, 0, 1'b0);

      // Lane 7 never valid: post cycle above is the first anyv & !allv cycle (cycle 0).
      skew_at = -1;
      rd_cnt  = 0;
      for (int c = 1; c <= 1100 && skew_at < 0; c++) begin
         cycle();
         look();
         if (o_rd_en) rd_cnt++;
         if (o_skew_err) skew_at = c;
      end
      chk("skew/at", skew_at, 1024);
      chk("skew/rd_en", rd_cnt, 0);
      chk("skew/flush", o_flush, 8'h7F);
      chk("skew/miss", o_lane_miss, 8'h80);
      chk("skew/symb", o_symb_idx, 2);
      fl = 1;
      skew_after = 0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         look();
         if (o_flush == 8'h7F) fl++;
         if (o_skew_err) skew_after++;
      end
      chk("skew/flush_len", fl, 4);
      chk("skew/pulse_len", skew_after, 0);
      chk("skew/flush_off", o_flush, 0);
      chk("skew/miss_hold", o_lane_miss, 8'h80);
      chk("skew/symb_hold", o_symb_idx, 2);
      chk("skew/busy", o_busy, 1);

      // Frame pulse in WAIT clears position and miss history on the next edge.
      cycle();
      i_rx_rfp = 1'b1;
      look();
      cycle();
      i_rx_rfp = 1'b0;
      look();
      chk("rfp_wait/symb", o_symb_idx, 0);
      chk("rfp_wait/slot", o_slot_idx, 0);
      chk("rfp_wait/miss", o_lane_miss, 0);

      // Disable at beat 20.
      cnt = 0;
      for (int g = 0; g < 200; g++) begin
         cycle();
         i_buf_vld = 8'hFF;
         if (cnt == 20) i_enable = 1'b0;
         look();
         if (cnt == 20) break;
         if (o_rd_en) cnt++;
      end
      chk("dis/beats", cnt, 20);
      chk("dis/rd_en", o_rd_en, 0);
      chk("dis/beat", o_beat, 20);
      cycle();
      look();
      chk("dis/busy", o_busy, 0);
      chk("dis/rd_en_next", o_rd_en, 0);
      chk("dis/beat_next", o_beat, 0);

      // Empty mask: WAIT forever, no reads, no timeout.
      cycle();
      i_enable = 1'b1; i_lane_mask = 8'h00; i_rx_rfp = 1'b1;
      look();
      cycle();
      i_rx_rfp = 1'b0;
      look();
      rd_cnt = 0;
      sk = 0;
      for (int c = 0; c < 300; c++) begin
         cycle();
         look();
         if (o_rd_en) rd_cnt++;
         if (o_skew_err) sk++;
      end
      chk("mask0/rd_en", rd_cnt, 0);
      chk("mask0/skew", sk, 0);
      chk("mask0/busy", o_busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
